vx_gpr_bank_responder: RTL and testbench



---
 rtl/vx_gpr_bank_responder.sv | 230 +++++++++++++++++++++++
 tb/tb_vx_gpr_bank_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_gpr_bank_responder.sv
// GPR bank responder: banked 1R1W register rows with a masked writeback port,
// a fixed 2-cycle read pipeline and post-reset zero-clearing. Optional macro: GPR_RW_BYPASS_EN.
module vx_gpr_bank_responder #(
  parameter int NUM_WIS    = 4,
  parameter int NUM_SIMD   = 2,
  parameter int NUM_REGS   = 32,
  parameter int SIMD_WIDTH = 4,
  parameter int XLEN       = 32,
  parameter int OPD_W      = 2,
  localparam int WIS_W     = (NUM_WIS > 1) ? $clog2(NUM_WIS) : 1,
  localparam int SID_W     = (NUM_SIMD > 1) ? $clog2(NUM_SIMD) : 1,
  localparam int REG_W     = $clog2(NUM_REGS),
  localparam int ROW_W     = SIMD_WIDTH * XLEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  input  logic [OPD_W-1:0]      req_opd_id,
  input  logic [WIS_W-1:0]      req_wis,
  input  logic [SID_W-1:0]      req_sid,
  input  logic [REG_W-1:0]      req_reg_id,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [OPD_W-1:0]      rsp_opd_id,
  output logic [ROW_W-1:0]      rsp_data,
  input  logic                  wr_valid,
  input  logic [WIS_W-1:0]      wr_wis,
  input  logic [SID_W-1:0]      wr_sid,
  input  logic [REG_W-1:0]      wr_reg_id,
  input  logic [SIMD_WIDTH-1:0] wr_mask,
  input  logic [ROW_W-1:0]      wr_data,
  output logic                  wr_ready,
  output logic                  init_done
);

  localparam int ADDR_W = WIS_W + SID_W + REG_W;
  localparam int DEPTH  = NUM_WIS * NUM_SIMD * NUM_REGS;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       init_cnt_q, init_cnt_d;
  logic                    ready_q, ready_d;

  logic                    s1_valid_q, s1_valid_d;
  logic [OPD_W-1:0]        s1_opd_q, s1_opd_d;
  logic                    s1_zero_q, s1_zero_d;

  logic                    rsp_valid_q, rsp_valid_d;
  logic [OPD_W-1:0]        rsp_opd_q, rsp_opd_d;
  logic [ROW_W-1:0]        rsp_data_q, rsp_data_d;

  logic [ROW_W-1:0]        mem_q [DEPTH];
  logic [ROW_W-1:0]        mem_rdata_q;

  logic                    rd_fire_s;
  logic                    wr_fire_s;
  logic [ADDR_W-1:0]       rd_addr_s;
  logic [ADDR_W-1:0]       wr_addr_s;
  logic                    mem_we_s;
  logic [ADDR_W-1:0]       mem_waddr_s;
  logic [ROW_W-1:0]        mem_wdata_s;
  logic [SIMD_WIDTH-1:0]   mem_wmask_s;
  logic [ROW_W-1:0]        s1_row_s;

  assign rd_addr_s = {req_wis, req_sid, req_reg_id};
  assign wr_addr_s = {wr_wis, wr_sid, wr_reg_id};
  // Register 0 is never stored, so its writes are dropped at the port.
  assign rd_fire_s = req_valid && ready_q;
  assign wr_fire_s = wr_valid && ready_q && (wr_reg_id != REG_W'(0));

  // Init/run sequencing and selection of the single array write port.
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = init_cnt_q;
    mem_wdata_s = '0;
    mem_wmask_s = '1;
    case (state_q)
      ST_INIT: begin
        mem_we_s   = 1'b1;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN: begin
        if (wr_fire_s) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = wr_addr_s;
          mem_wdata_s = wr_data;
          mem_wmask_s = wr_mask;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  // Stage 1 capture of request metadata alongside the synchronous array read.
  always_comb begin
    s1_valid_d = rd_fire_s;
    if (rd_fire_s) begin
      s1_opd_d  = req_opd_id;
      s1_zero_d = (req_reg_id == REG_W'(0));
    end else begin
      s1_opd_d  = s1_opd_q;
      s1_zero_d = s1_zero_q;
    end
  end

`ifdef GPR_RW_BYPASS_EN
  logic                  byp_hit_q, byp_hit_d;
  logic [SIMD_WIDTH-1:0] byp_mask_q, byp_mask_d;
  logic [ROW_W-1:0]      byp_data_q, byp_data_d;

  // Compare read and write rows in the accept cycle; the result is consumed next cycle.
  always_comb begin
    byp_hit_d = rd_fire_s && wr_fire_s && (rd_addr_s == wr_addr_s);
    if (byp_hit_d) begin
      byp_mask_d = wr_mask;
      byp_data_d = wr_data;
    end else begin
      byp_mask_d = byp_mask_q;
      byp_data_d = byp_data_q;
    end
  end

  // Bypass flops for the colliding write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      byp_hit_q  <= 1'b0;
      byp_mask_q <= '0;
      byp_data_q <= '0;
    end else begin
      byp_hit_q  <= byp_hit_d;
      byp_mask_q <= byp_mask_d;
      byp_data_q <= byp_data_d;
    end
  end

  // Per-lane merge of freshly written lanes over the old array row.
  always_comb begin
    s1_row_s = mem_rdata_q;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      if (byp_hit_q && byp_mask_q[i]) begin
        s1_row_s[i*XLEN +: XLEN] = byp_data_q[i*XLEN +: XLEN];
      end else begin
        s1_row_s[i*XLEN +: XLEN] = mem_rdata_q[i*XLEN +: XLEN];
      end
    end
  end
`else
  assign s1_row_s = mem_rdata_q;
`endif

  // Stage 2 output register; data and tag hold between responses.
  always_comb begin
    rsp_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      rsp_opd_d = s1_opd_q;
      if (s1_zero_q) begin
        rsp_data_d = '0;
      end else begin
        rsp_data_d = s1_row_s;
      end
    end else begin
      rsp_opd_d  = rsp_opd_q;
      rsp_data_d = rsp_data_q;
    end
  end

  // Control, pipeline and output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      ready_q     <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_opd_q    <= '0;
      s1_zero_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_opd_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ready_q     <= ready_d;
      s1_valid_q  <= s1_valid_d;
      s1_opd_q    <= s1_opd_d;
      s1_zero_q   <= s1_zero_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_opd_q   <= rsp_opd_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Register array: masked lane writes, read-before-write synchronous read.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        if (mem_wmask_s[i]) begin
          mem_q[mem_waddr_s][i*XLEN +: XLEN] <= mem_wdata_s[i*XLEN +: XLEN];
        end
      end
    end
    if (rd_fire_s) begin
      mem_rdata_q <= mem_q[rd_addr_s];
    end
  end

  assign req_ready  = ready_q;
  assign wr_ready   = ready_q;
  assign init_done  = ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_opd_id = rsp_opd_q;
  assign rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_vx_gpr_bank_responder.sv
// Directed self-checking bench for vx_gpr_bank_responder (default parameters).
module tb_vx_gpr_bank_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         req_valid;
  logic [1:0]   req_opd_id;
  logic [1:0]   req_wis;
  logic [0:0]   req_sid;
  logic [4:0]   req_reg_id;
  logic         req_ready;
  logic         rsp_valid;
  logic [1:0]   rsp_opd_id;
  logic [127:0] rsp_data;
  logic         wr_valid;
  logic [1:0]   wr_wis;
  logic [0:0]   wr_sid;
  logic [4:0]   wr_reg_id;
  logic [3:0]   wr_mask;
  logic [127:0] wr_data;
  logic         wr_ready;
  logic         init_done;

  int n_cmp = 0;
  int n_err = 0;
  int edges;

  logic [127:0] row_full;
  logic [127:0] row_part;
  logic [127:0] row_five;
  logic [127:0] exp_coll;

  vx_gpr_bank_responder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_opd_id (req_opd_id),
    .req_wis    (req_wis),
    .req_sid    (req_sid),
    .req_reg_id (req_reg_id),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_opd_id (rsp_opd_id),
    .rsp_data   (rsp_data),
    .wr_valid   (wr_valid),
    .wr_wis     (wr_wis),
    .wr_sid     (wr_sid),
    .wr_reg_id  (wr_reg_id),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] opd, input logic [1:0] wis, input logic [0:0] sid,
                         input logic [4:0] rid);
    req_valid  = 1'b1;
    req_opd_id = opd;
    req_wis    = wis;
    req_sid    = sid;
    req_reg_id = rid;
  endtask

  task automatic set_wr(input logic [1:0] wis, input logic [0:0] sid, input logic [4:0] rid,
                        input logic [3:0] mask, input logic [127:0] data);
    wr_valid  = 1'b1;
    wr_wis    = wis;
    wr_sid    = sid;
    wr_reg_id = rid;
    wr_mask   = mask;
    wr_data   = data;
  endtask

  task automatic wait_init(input string tag);
    edges = 0;
    while (!req_ready && edges < 400) begin
      step();
      edges++;
    end
    chk(tag, 128'(edges), 128'd256);
    chk({tag, "_done"}, {125'd0, req_ready, wr_ready, init_done}, 128'd7);
  endtask

  initial begin
    row_full = {32'h44, 32'h33, 32'h22, 32'h11};
    row_part = {32'h44, 32'hAA, 32'h22, 32'hAA};
    row_five = {4{32'h5}};
`ifdef GPR_RW_BYPASS_EN
    exp_coll = row_five;
`else
    exp_coll = 128'd0;
`endif
    reset_n = 1'b0;
    req_valid = 1'b0; req_opd_id = 2'd0; req_wis = 2'd0; req_sid = 1'b0; req_reg_id = 5'd0;
    wr_valid = 1'b0; wr_wis = 2'd0; wr_sid = 1'b0; wr_reg_id = 5'd0; wr_mask = 4'h0;
    wr_data = 128'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {125'd0, req_ready, wr_ready, init_done}, 128'd0);
    chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset_rsp_opd", 128'(rsp_opd_id), 128'd0);
    chk("reset_rsp_data", rsp_data, 128'd0);

    reset_n = 1'b1;
    wait_init("init_len");

    // First read of the last row after clearing.
    set_req(2'd1, 2'd3, 1'b1, 5'd31);
    step();
    req_valid = 1'b0;
    chk("rd31_not_early", 128'(rsp_valid), 128'd0);
    step();
    chk("rd31_valid", 128'(rsp_valid), 128'd1);
    chk("rd31_opd", 128'(rsp_opd_id), 128'd1);
    chk("rd31_data", rsp_data, 128'd0);
    step();
    chk("rd31_pulse", 128'(rsp_valid), 128'd0);

    // Full write then read on the next cycle.
    set_wr(2'd1, 1'b0, 5'd5, 4'hF, row_full);
    step();
    wr_valid = 1'b0;
    set_req(2'd2, 2'd1, 1'b0, 5'd5);
    step();
    req_valid = 1'b0;
    chk("wr_rd_not_early", 128'(rsp_valid), 128'd0);
    step();
    chk("wr_rd_valid", 128'(rsp_valid), 128'd1);
    chk("wr_rd_opd", 128'(rsp_opd_id), 128'd2);
    chk("wr_rd_data", rsp_data, row_full);
    step();
    chk("wr_rd_pulse", 128'(rsp_valid), 128'd0);
    chk("wr_rd_hold", rsp_data, row_full);

    // Partial-mask write.
    set_wr(2'd1, 1'b0, 5'd5, 4'b0101, {4{32'hAA}});
    step();
    wr_valid = 1'b0;
    set_req(2'd3, 2'd1, 1'b0, 5'd5);
    step();
    req_valid = 1'b0;
    step();
    chk("part_opd", 128'(rsp_opd_id), 128'd3);
    chk("part_data", rsp_data, row_part);

    // Register 0 write ignored; three back-to-back reads.
    set_wr(2'd1, 1'b0, 5'd0, 4'hF, {4{32'hFFFFFFFF}});
    step();
    wr_valid = 1'b0;
    set_req(2'd0, 2'd1, 1'b0, 5'd0);
    step();
    set_req(2'd1, 2'd1, 1'b0, 5'd5);
    step();
    chk("b2b0_valid", 128'(rsp_valid), 128'd1);
    chk("b2b0_opd", 128'(rsp_opd_id), 128'd0);
    chk("b2b0_data", rsp_data, 128'd0);
    set_req(2'd2, 2'd1, 1'b0, 5'd0);
    step();
    req_valid = 1'b0;
    chk("b2b1_valid", 128'(rsp_valid), 128'd1);
    chk("b2b1_opd", 128'(rsp_opd_id), 128'd1);
    chk("b2b1_data", rsp_data, row_part);
    step();
    chk("b2b2_valid", 128'(rsp_valid), 128'd1);
    chk("b2b2_opd", 128'(rsp_opd_id), 128'd2);
    chk("b2b2_data", rsp_data, 128'd0);
    step();
    chk("b2b_end_valid", 128'(rsp_valid), 128'd0);
    chk("b2b_end_opd_hold", 128'(rsp_opd_id), 128'd2);

    // Same-cycle read and write of one row.
    set_wr(2'd2, 1'b1, 5'd7, 4'hF, row_five);
    set_req(2'd3, 2'd2, 1'b1, 5'd7);
    step();
    wr_valid = 1'b0;
    req_valid = 1'b0;
    step();
    chk("coll_valid", 128'(rsp_valid), 128'd1);
    chk("coll_data", rsp_data, exp_coll);
    set_req(2'd0, 2'd2, 1'b1, 5'd7);
    step();
    req_valid = 1'b0;
    step();
    chk("coll_after_data", rsp_data, row_five);

    // Reset while a request is in flight.
    set_req(2'd3, 2'd1, 1'b0, 5'd5);
    step();
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rst_ready", 128'(req_ready), 128'd0);
    edges = 0;
    repeat (3) begin
      step();
      if (rsp_valid) edges++;
    end
    chk("mid_rst_no_pulse", 128'(edges), 128'd0);
    chk("mid_rst_data", rsp_data, 128'd0);
    reset_n = 1'b1;
    wait_init("reinit_len");

    set_req(2'd1, 2'd1, 1'b0, 5'd5);
    step();
    set_req(2'd2, 2'd2, 1'b1, 5'd7);
    step();
    req_valid = 1'b0;
    chk("reinit_rd5_opd", 128'(rsp_opd_id), 128'd1);
    chk("reinit_rd5_data", rsp_data, 128'd0);
    step();
    chk("reinit_rd7_opd", 128'(rsp_opd_id), 128'd2);
    chk("reinit_rd7_data", rsp_data, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
